// File: rtl/barrel_sweep_sequencer.sv
// Command-driven sweep sequencer: registers a data word and steps the shift amount
// fed to a downstream barrel shifter, capturing each result into a backpressured stream.
module barrel_sweep_sequencer #(
    parameter int N        = 4,
    parameter int NUM_BITS = 2 ** N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [NUM_BITS-1:0] s_data,
    input  logic [N-1:0]        s_first,
    input  logic [N-1:0]        s_step,
    input  logic [N:0]          s_len,
    output logic [NUM_BITS-1:0] sh_in,
    output logic [N-1:0]        sh_amount,
    input  logic [NUM_BITS-1:0] sh_out,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [NUM_BITS-1:0] m_data,
    output logic [N-1:0]        m_amount,
    output logic                m_last,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        LAST_WAIT = 2'd2
    } state_t;

    localparam logic [N:0] LEN_ONE  = (N+1)'(1);
    localparam logic [N:0] LEN_ZERO = (N+1)'(0);

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] sh_in_q, sh_in_d;
    logic [N-1:0]        sh_amount_q, sh_amount_d;
    logic [N-1:0]        step_q, step_d;
    logic [N:0]          remaining_q, remaining_d;
    logic                m_valid_q, m_valid_d;
    logic [NUM_BITS-1:0] m_data_q, m_data_d;
    logic [N-1:0]        m_amount_q, m_amount_d;
    logic                m_last_q, m_last_d;
    logic                busy_q, busy_d;
    logic                load_s;

    assign load_s = !m_valid_q || m_ready;

    // Next-state and datapath decode; every register holds unless a rule below moves it.
    always_comb begin
        state_d     = state_q;
        sh_in_d     = sh_in_q;
        sh_amount_d = sh_amount_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_amount_d  = m_amount_q;
        m_last_d    = m_last_q;

        // A consumed result drops unless a new one is loaded over it below.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
            m_last_d  = m_last_q;
        end

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    sh_in_d     = s_data;
                    sh_amount_d = s_first;
                    step_d      = s_step;
                    remaining_d = s_len;
                    if (s_len != LEN_ZERO) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (load_s) begin
                    m_data_d    = sh_out;
                    m_amount_d  = sh_amount_q;
                    m_last_d    = (remaining_q == LEN_ONE);
                    m_valid_d   = 1'b1;
                    sh_amount_d = sh_amount_q + step_q;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = LAST_WAIT;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            LAST_WAIT: begin
                if (m_valid_q && m_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = LAST_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers, cleared asynchronously so a reset abandons any sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_in_q     <= {NUM_BITS{1'b0}};
            sh_amount_q <= {N{1'b0}};
            step_q      <= {N{1'b0}};
            remaining_q <= {(N+1){1'b0}};
            m_valid_q   <= 1'b0;
            m_data_q    <= {NUM_BITS{1'b0}};
            m_amount_q  <= {N{1'b0}};
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_in_q     <= sh_in_d;
            sh_amount_q <= sh_amount_d;
            step_q      <= step_d;
            remaining_q <= remaining_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_amount_q  <= m_amount_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready   = (state_q == IDLE);
    assign sh_in     = sh_in_q;
    assign sh_amount = sh_amount_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_amount  = m_amount_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_barrel_sweep_sequencer.sv
// Bench for barrel_sweep_sequencer: a rotate-left shifter stand-in, a queue-based
// result model compared every cycle, and directed sweeps with literal expectations.
module tb_barrel_sweep_sequencer;

    localparam int N  = 4;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [NB-1:0] s_data;
    logic [N-1:0]  s_first;
    logic [N-1:0]  s_step;
    logic [N:0]    s_len;
    logic [NB-1:0] sh_in;
    logic [N-1:0]  sh_amount;
    logic [NB-1:0] sh_out;
    logic          m_valid;
    logic          m_ready;
    logic [NB-1:0] m_data;
    logic [N-1:0]  m_amount;
    logic          m_last;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit rand_ready = 1'b0;

    typedef struct {
        logic [NB-1:0] d;
        logic [N-1:0]  a;
        logic          l;
    } item_t;

    item_t         pend[$];
    item_t         cur;
    bit            ov   = 1'b0;
    bit            idle = 1'b1;
    logic [N-1:0]  log_amt[$];
    logic [NB-1:0] log_dat[$];
    logic          log_last[$];

    always #5 clk = ~clk;

    function automatic logic [NB-1:0] rotl(input logic [NB-1:0] d, input logic [N-1:0] a);
        logic [2*NB-1:0] t;
        t = {d, d} << a;
        return t[2*NB-1:NB];
    endfunction

    assign sh_out = rotl(sh_in, sh_amount);

    barrel_sweep_sequencer #(.N(N), .NUM_BITS(NB)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_first(s_first), .s_step(s_step), .s_len(s_len),
        .sh_in(sh_in), .sh_amount(sh_amount), .sh_out(sh_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_amount(m_amount), .m_last(m_last), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending results per accepted command, one presented item, consumed on handshake.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                pend.delete();
                ov   = 1'b0;
                idle = 1'b1;
            end else begin
                bit ov_old;
                ov_old = ov;
                if (ov && m_ready) begin
                    log_amt.push_back(m_amount);
                    log_dat.push_back(m_data);
                    log_last.push_back(m_last);
                    ov = 1'b0;
                end
                if (idle) begin
                    if (s_valid) begin
                        for (int i = 0; i < int'(s_len); i++) begin
                            item_t it;
                            it.a = N'((int'(s_first) + i * int'(s_step)) % 16);
                            it.d = rotl(s_data, it.a);
                            it.l = (i == int'(s_len) - 1);
                            pend.push_back(it);
                        end
                        if (s_len != 5'd0) idle = 1'b0;
                    end
                end else if (!ov_old || m_ready) begin
                    if (pend.size() > 0) begin
                        cur = pend.pop_front();
                        ov  = 1'b1;
                    end else begin
                        idle = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model plus hold-under-stall check.
    initial begin
        bit            was_stall = 1'b0;
        logic [NB-1:0] pd;
        logic [N-1:0]  pa;
        logic          pl;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("m_valid", {31'd0, m_valid}, {31'd0, ov});
                chk("busy", {31'd0, busy}, {31'd0, !idle});
                chk("s_ready", {31'd0, s_ready}, {31'd0, idle});
                if (ov) begin
                    chk("m_amount", {28'd0, m_amount}, {28'd0, cur.a});
                    chk("m_data", {16'd0, m_data}, {16'd0, cur.d});
                    chk("m_last", {31'd0, m_last}, {31'd0, cur.l});
                end
                if (was_stall) begin
                    chk("stall_hold", {11'd0, m_data, m_amount, m_last}, {11'd0, pd, pa, pl});
                end
                was_stall = m_valid && !m_ready;
                pd = m_data;
                pa = m_amount;
                pl = m_last;
            end else begin
                was_stall = 1'b0;
            end
        end
    end

    task automatic send(input logic [NB-1:0] d, input logic [N-1:0] f,
                        input logic [N-1:0] st, input logic [N:0] len);
        s_data  = d;
        s_first = f;
        s_step  = st;
        s_len   = len;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (log_amt.size() >= n && s_ready) begin
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        m_ready = 1'b1;
        chk("timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic clear_log();
        log_amt.delete();
        log_dat.delete();
        log_last.delete();
    endtask

    initial begin
        int nlast;
        logic [N-1:0] exp_ws[4];
        logic [N-1:0] exp_bi[4];
        exp_ws = '{4'd14, 4'd3, 4'd8, 4'd13};
        exp_bi = '{4'd2, 4'd5, 4'd8, 4'd11};
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        s_data = 16'h0000; s_first = 4'd0; s_step = 4'd0; s_len = 5'd0;
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_outs", {m_data, m_amount, m_last, 11'd0}, 32'd0);
        chk("rst_sh", {sh_in, sh_amount, 12'd0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full sweep
        clear_log();
        send(16'h8001, 4'd0, 4'd1, 5'd16);
        wait_done(16, 100);
        nlast = 0;
        for (int i = 0; i < 16 && i < log_amt.size(); i++) begin
            chk("sweep_amt", {28'd0, log_amt[i]}, i);
            nlast += int'(log_last[i]);
        end
        chk("sweep_count", log_amt.size(), 32'd16);
        chk("sweep_nlast", nlast, 32'd1);
        if (log_amt.size() == 16) begin
            chk("sweep_last15", {31'd0, log_last[15]}, 32'd1);
            chk("sweep_dat1", {16'd0, log_dat[1]}, 32'h0003);
            chk("sweep_dat15", {16'd0, log_dat[15]}, 32'hC000);
        end
        chk("sweep_busy_low", {31'd0, busy}, 32'd0);

        // Wrap and stride
        clear_log();
        send(16'h1234, 4'd14, 4'd5, 5'd4);
        wait_done(4, 50);
        chk("ws_count", log_amt.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_amt.size(); i++) begin
            chk("ws_amt", {28'd0, log_amt[i]}, {28'd0, exp_ws[i]});
            chk("ws_last", {31'd0, log_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Backpressure
        clear_log();
        rand_ready = 1'b1;
        send(16'h8001, 4'd0, 4'd1, 5'd16);
        wait_done(16, 400);
        rand_ready = 1'b0;
        chk("bp_count", log_amt.size(), 32'd16);
        for (int i = 0; i < 16 && i < log_amt.size(); i++) begin
            chk("bp_amt", {28'd0, log_amt[i]}, i);
        end

        // Zero length
        clear_log();
        send(16'hABCD, 4'd3, 4'd1, 5'd0);
        repeat (4) begin
            chk("zl_s_ready", {31'd0, s_ready}, 32'd1);
            chk("zl_busy", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("zl_count", log_amt.size(), 32'd0);

        // Commands while running are ignored
        send(16'h00F0, 4'd2, 4'd3, 5'd4);
        s_data = 16'hFFFF; s_first = 4'd9; s_step = 4'd1; s_len = 5'd8;
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_valid = 1'b0;
        wait_done(4, 50);
        repeat (3) @(posedge clk);
        #1;
        chk("bi_count", log_amt.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_amt.size(); i++) begin
            chk("bi_amt", {28'd0, log_amt[i]}, {28'd0, exp_bi[i]});
            chk("bi_dat", {16'd0, log_dat[i]}, {16'd0, rotl(16'h00F0, exp_bi[i])});
        end

        // Reset mid-run
        clear_log();
        send(16'h8001, 4'd0, 4'd1, 5'd16);
        for (int c = 0; c < 50 && log_amt.size() < 3; c++) @(posedge clk);
        chk("mid_reached3", log_amt.size(), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_s_ready", {31'd0, s_ready}, 32'd1);
        chk("mid_outs", {m_data, m_amount, m_last, 11'd0}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        send(16'h8001, 4'd7, 4'd1, 5'd2);
        wait_done(2, 50);
        repeat (3) @(posedge clk);
        #1;
        chk("post_count", log_amt.size(), 32'd2);
        if (log_amt.size() >= 2) begin
            chk("post_amt0", {28'd0, log_amt[0]}, 32'd7);
            chk("post_amt1", {28'd0, log_amt[1]}, 32'd8);
            chk("post_last1", {31'd0, log_last[1]}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_sweep_sequencer.md
# barrel_sweep_sequencer

Command-driven sequencer that sits directly upstream of `parameterized_barrel_shifter` and consumes its result. It accepts one data word plus a sweep description over a valid/ready handshake. It then steps the shift amount once per cycle and drives the shifter's data and amount inputs from registers. It captures each shifter output, tagged with the amount that produced it, into a backpressured result stream.

## Interface
- `N`, default 4: width of the shift amount.
- `NUM_BITS`, default `2**N`: data width.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `s_valid`  input  1  command valid.
- `s_ready`  output  1  command ready; high only in IDLE.
- `s_data`  input  NUM_BITS  word to sweep.
- `s_first`  input  N  first shift amount.
- `s_step`  input  N  amount increment per result, modulo 2^N.
- `s_len`  input  N+1  number of results to produce; 0 is legal.
- `sh_in`  output  NUM_BITS  to shifter `in`; registered copy of `s_data`.
- `sh_amount`  output  N  to shifter `shift_amount`; registered current amount.
- `sh_out`  input  NUM_BITS  from shifter `out`; combinational function of `sh_in` and `sh_amount`.
- `m_valid`  output  1  result valid.
- `m_ready`  input  1  result ready.
- `m_data`  output  NUM_BITS  captured `sh_out`.
- `m_amount`  output  N  amount that produced `m_data`.
- `m_last`  output  1  marks the final result of a command.
- `busy`  output  1  high whenever state is not IDLE.

## Operation
- States are IDLE, RUN and LAST_WAIT. The reset state is IDLE.
- **IDLE:** `s_ready`=1. When `s_valid` is high on a clock edge:
  - `sh_in` <= `s_data`, `sh_amount` <= `s_first`, `step` <= `s_step`, `remaining` <= `s_len`.
  - Go to RUN if `s_len`!=0; otherwise stay in IDLE with no output.
- **RUN:** load = `!m_valid || m_ready`. On a load edge:
  - `m_data` <= `sh_out`, `m_amount` <= `sh_amount`, `m_last` <= (`remaining`==1), `m_valid` <= 1.
  - `sh_amount` <= `sh_amount` + `step` (N-bit wrap).
  - `remaining` <= `remaining` - 1.
  - If `remaining`==1, go to LAST_WAIT.
- **RUN without a load:** when `m_valid && !m_ready`, all registers hold.
- **LAST_WAIT:** on `m_valid && m_ready`, clear `m_valid`/`m_last` and go to IDLE.
- **Commands while not IDLE:** `s_valid` outside IDLE is ignored; it is neither accepted nor queued.
- **Output clear outside load:** `m_valid` clears on a `m_ready` edge with no load.
- **Amount arithmetic:**
  - Amounts wrap modulo 2^N.
  - `s_len` > 2^N is legal and repeats amounts.
  - `s_step`=0 produces `s_len` identical results.
- **Output stability:** while `m_valid && !m_ready`, `m_data`, `m_amount` and `m_last` are stable.
- **Reset values:**
  - `m_valid`=0, `m_last`=0, `m_data`=0, `m_amount`=0.
  - `sh_in`=0, `sh_amount`=0, `busy`=0.
  - `s_ready`=1, because it decodes from IDLE.
- **Reset mid-command:** all of the above values apply immediately and asynchronously. The command is abandoned with no partial completion, and `s_ready` is available on the first edge after `rst_n` rises.

## Timing
- Command accepted at edge E0.
- First result: `m_valid` is high after edge E1 with `m_amount`=`s_first`.
- Throughput is one result per cycle while `m_ready`=1. For `s_len`=L with no stalls:
  - the last result is valid after E_L;
  - the handshake at E_{L+1} returns to IDLE;
  - the next command can be accepted at E_{L+2}.
- `s_len`=0: `busy` never asserts, and `s_ready` stays 1 continuously.
- A stall holds the sweep exactly; no amount is skipped or duplicated.
- `busy` is registered-state-derived and has no combinational path from `s_valid`.
- The only combinational input-to-output dependencies are:
  - `s_ready`, from state only;
  - the `sh_out` path, which is captured, never forwarded.

## Test plan
- **Full sweep:** `s_data`=16'h8001, `s_first`=0, `s_step`=1, `s_len`=16, `m_ready`=1. Required response:
  - amounts 0..15 on 16 consecutive cycles;
  - `m_data` matches the shifter model for each amount;
  - `m_last` only on amount 15;
  - `busy` falls after the last handshake.
- **Wrap and stride:** `s_first`=14, `s_step`=5, `s_len`=4 -> amounts 14, 3, 8, 13 with `m_last` on 13.
- **Backpressure:** same command as full sweep with `m_ready` toggling pseudo-randomly. Required response:
  - each amount appears exactly once, in order;
  - outputs are stable across every stalled cycle.
- **Zero length and busy-ignore:**
  - `s_len`=0 -> no `m_valid`, `s_ready` stays 1.
  - A second `s_valid` asserted during a RUN is not accepted, and output is unchanged.
- **Reset mid-run:** drop `rst_n` after 3 of 16 results. Required response:
  - `m_valid`=0 and `busy`=0 immediately;
  - after release, a fresh command (`s_first`=7, `s_len`=2) yields amounts 7, 8 only.
